// File: rtl/seg7_pkg.sv
// Shared definitions for the 6-digit multiplexed 7-segment display driver.
//   NUM_DIGITS : number of digits on the display
//   SEG_CODE   : hex nibble -> active-low segment code {dp,g,f,e,d,c,b,a}, dp off
//   SEG_OFF    : all segments dark (active-low)
//   SEL_OFF    : no digit selected (active-low)
//   digit_nibble() : pick the nibble shown on digit k (digit 0 = leftmost)
package seg7_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [7:0] SEG_CODE [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [5:0] SEL_OFF = 6'h3F;

  // Digit 0 is the most significant nibble of the packed value.
  function automatic logic [3:0] digit_nibble(input logic [23:0] v, input logic [2:0] k);
    case (k)
      3'd0:    return v[23:20];
      3'd1:    return v[19:16];
      3'd2:    return v[15:12];
      3'd3:    return v[11:8];
      3'd4:    return v[7:4];
      3'd5:    return v[3:0];
      default: return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-segment decoder (active-low outputs).
//   nibble : hex digit to display
//   blank  : 1 = segments a..g dark (leading-zero suppression)
//   dp     : 1 = decimal point lit; independent of blank
//   seg    : {dp,g,f,e,d,c,b,a}, active-low
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg = {~dp, (blank ? 7'h7F : SEG_CODE[nibble][6:0])};
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 6-digit common-anode 7-segment display.
// Shows a 24-bit value as six hex digits with frame-synchronous update,
// optional leading-zero blanking, per-digit decimal points and a short
// all-dark gap at the start of every digit slot to suppress ghosting.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   idata     : value to display, [23:20] = leftmost digit
//   ivalid    : one-cycle strobe capturing idata/idp
//   idp       : decimal-point enables, bit k = digit k (0 = leftmost)
//   iblank_lz : leading-zero blanking enable, sampled at frame start
//   SEL       : digit select, active-low
//   DIG       : segments {dp,g,f,e,d,c,b,a}, active-low
//   oframe    : one-cycle pulse with the first output cycle of a frame
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] idata,
  input  logic        ivalid,
  input  logic [5:0]  idp,
  input  logic        iblank_lz,
  output logic [5:0]  SEL,
  output logic [7:0]  DIG,
  output logic        oframe
);

  localparam int            CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0]           cnt_p0;
  logic [2:0]              idx_p0;
  logic [23:0]             pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_flag;
  logic [23:0]             shown_val;
  logic [NUM_DIGITS-1:0]   shown_dp;
  logic                    shown_blz;

  logic [23:0]             shown_val_nxt;
  logic [NUM_DIGITS-1:0]   shown_dp_nxt;
  logic                    shown_blz_nxt;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    frame_start;
  logic                    slot_end;
  logic                    in_gap;
  logic [3:0]              cur_nib;
  logic [7:0]              dec_seg;

  logic [5:0]              sel_p1;
  logic [7:0]              dig_p1;
  logic                    frame_p1;

  assign frame_start = (cnt_p0 == '0) && (idx_p0 == 3'd0);
  assign slot_end    = (cnt_p0 == CNT_LAST);
  assign in_gap      = (int'(cnt_p0) < BLANK_CYC);

  // Stage p0: slot counter and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0 <= '0;
      idx_p0 <= 3'd0;
    end else if (slot_end) begin
      cnt_p0 <= '0;
      idx_p0 <= (idx_p0 == 3'd5) ? 3'd0 : idx_p0 + 3'd1;
    end else begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

  // The value decoded this cycle is the one that will be held after this
  // edge, so a commit is visible from the very first slot of the frame even
  // with the blanking gap disabled. An ivalid on the commit cycle bypasses
  // the pending register.
  always_comb begin
    shown_val_nxt = shown_val;
    shown_dp_nxt  = shown_dp;
    shown_blz_nxt = shown_blz;
    if (frame_start) begin
      shown_blz_nxt = iblank_lz;
      if (ivalid) begin
        shown_val_nxt = idata;
        shown_dp_nxt  = idp;
      end else if (pend_flag) begin
        shown_val_nxt = pend_val;
        shown_dp_nxt  = pend_dp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      shown_val <= '0;
      shown_dp  <= '0;
      shown_blz <= 1'b0;
    end else begin
      if (ivalid) begin
        pend_val <= idata;
        pend_dp  <= idp;
      end
      if (frame_start)
        pend_flag <= 1'b0;
      else if (ivalid)
        pend_flag <= 1'b1;
      shown_val <= shown_val_nxt;
      shown_dp  <= shown_dp_nxt;
      shown_blz <= shown_blz_nxt;
    end
  end

  // A digit is a leading zero while it and every digit left of it are zero;
  // the rightmost digit always shows so a zero value still reads "0".
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = 0; k < NUM_DIGITS - 1; k++) begin
      zero_run   = zero_run && (shown_val_nxt[4*(5-k) +: 4] == 4'h0);
      lz_mask[k] = shown_blz_nxt && zero_run;
    end
  end

  assign cur_nib = digit_nibble(shown_val_nxt, idx_p0);

  seg7_hex_decode u_dec (
    .nibble (cur_nib),
    .blank  (lz_mask[idx_p0]),
    .dp     (shown_dp_nxt[idx_p0]),
    .seg    (dec_seg)
  );

  // Stage p1: registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_p1   <= SEL_OFF;
      dig_p1   <= SEG_OFF;
      frame_p1 <= 1'b0;
    end else begin
      sel_p1   <= in_gap ? SEL_OFF : ~(6'd1 << idx_p0);
      dig_p1   <= in_gap ? SEG_OFF : dec_seg;
      frame_p1 <= frame_start;
    end
  end

  assign SEL    = sel_p1;
  assign DIG    = dig_p1;
  assign oframe = frame_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 6 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] idata = '0;
  logic        ivalid = 1'b0;
  logic [5:0]  idp = '0;
  logic        iblank_lz = 1'b0;
  logic [5:0]  SEL;
  logic [7:0]  DIG;
  logic        oframe;

  int errors = 0;
  int checks = 0;
  int n = 0;

  // reference model state
  logic [23:0] m_pend, m_shown;
  logic [5:0]  m_pdp, m_sdp;
  logic        m_flag, m_blz;

  logic [7:0] seg_tbl [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .idata     (idata),
    .ivalid    (ivalid),
    .idp       (idp),
    .iblank_lz (iblank_lz),
    .SEL       (SEL),
    .DIG       (DIG),
    .oframe    (oframe)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend = '0; m_shown = '0; m_pdp = '0; m_sdp = '0; m_flag = 1'b0; m_blz = 1'b0;
    n = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert (SEL === 6'h3F) else begin errors++; $error("FAIL %s_sel got %h exp 3f", tag, SEL); end
    checks++;
    assert (DIG === 8'hFF) else begin errors++; $error("FAIL %s_dig got %h exp ff", tag, DIG); end
    checks++;
    assert (oframe === 1'b0) else begin errors++; $error("FAIL %s_oframe got %b exp 0", tag, oframe); end
  endtask

  // One clock: update the model with the inputs present at the edge, then
  // compare the registered outputs 1 time unit later. ivalid is a strobe.
  task automatic step();
    int pos, k, c;
    logic [23:0] upper;
    logic [3:0]  nib;
    logic        blank;
    logic [5:0]  e_sel;
    logic [7:0]  e_dig;
    logic        e_frm;
    @(posedge clk);
    pos = n % FRAME;
    k   = pos / SD;
    c   = pos % SD;
    if (pos == 0) begin
      m_blz = iblank_lz;
      if (ivalid) begin
        m_shown = idata; m_sdp = idp; m_flag = 1'b0;
      end else if (m_flag) begin
        m_shown = m_pend; m_sdp = m_pdp; m_flag = 1'b0;
      end
    end else if (ivalid) begin
      m_pend = idata; m_pdp = idp; m_flag = 1'b1;
    end
    upper = m_shown >> (4 * (5 - k));
    nib   = upper[3:0];
    blank = m_blz && (k < 5) && (upper == 24'h0);
    e_frm = (pos == 0);
    if (c < BC) begin
      e_sel = 6'h3F;
      e_dig = 8'hFF;
    end else begin
      e_sel = 6'h3F ^ (6'd1 << k);
      e_dig = {~m_sdp[k], (blank ? 7'h7F : seg_tbl[nib][6:0])};
    end
    #1;
    checks++;
    assert (SEL === e_sel) else begin errors++; $error("FAIL sel n=%0d got %h exp %h", n, SEL, e_sel); end
    checks++;
    assert (DIG === e_dig) else begin errors++; $error("FAIL dig n=%0d got %h exp %h", n, DIG, e_dig); end
    checks++;
    assert (oframe === e_frm) else begin errors++; $error("FAIL oframe n=%0d got %b exp %b", n, oframe, e_frm); end
    n++;
    ivalid = 1'b0;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // advance until the next edge lands on frame position p
  task automatic run_to(input int p);
    for (int i = 0; i < FRAME && (n % FRAME) != p; i++) step();
  endtask

  task automatic strobe(input logic [23:0] d, input logic [5:0] dp);
    idata = d; idp = dp; ivalid = 1'b1;
    step();
  endtask

  initial begin
    model_reset();
    // reset held: outputs idle
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_reset_outputs("rst_hold");
    end
    rst_n = 1'b1;

    // first frame after reset shows 000000
    run(FRAME + 4);

    // mid-frame update: current frame unchanged, next frame shows ABCDEF
    run_to(20);
    strobe(24'hABCDEF, 6'h00);
    run_to(0);
    run(FRAME);

    // two updates in one frame: only the later is shown
    run_to(10);
    strobe(24'h123456, 6'h00);
    run(5);
    strobe(24'h654321, 6'h00);
    run_to(0);
    run(FRAME);

    // update exactly on the commit cycle: shown in that same frame
    run_to(30);
    strobe(24'h111111, 6'h00);
    run_to(0);
    strobe(24'h0F0E0D, 6'h00);
    run(FRAME - 1);

    // leading-zero blanking with decimal points on digits 0 and 5
    iblank_lz = 1'b1;
    run_to(5);
    strobe(24'h000A05, 6'b100001);
    run_to(0);
    run(FRAME);
    strobe(24'h000000, 6'b100001);
    run_to(0);
    run(FRAME);
    iblank_lz = 1'b0;

    // randomized updates, blanking level and decimal points
    for (int r = 0; r < 16; r++) begin
      logic [23:0] d;
      d = 24'($urandom) >> (4 * $urandom_range(0, 6));
      iblank_lz = 1'($urandom);
      run($urandom_range(1, 70));
      strobe(d, 6'($urandom));
    end
    run(2 * FRAME);

    // asynchronous reset in the middle of slot 3
    run_to(3 * SD + 4);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(posedge clk); #1;
    check_reset_outputs("async_rst_hold");
    rst_n = 1'b1;
    model_reset();
    iblank_lz = 1'b0;
    run(FRAME + SD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
